// File: rtl/sph_axil_pkg.sv
// Shared constants and types for the SPH AXI4-Lite register file.
package sph_axil_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = 8;

  typedef logic [IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_t;

endpackage

// File: rtl/sph_axil_hold_buf.sv
// One-deep valid/ready holding register with a registered ready output.
module sph_axil_hold_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             pop
);

  logic full_next;

  always_comb begin
    full_next = (out_valid && !pop) || (in_ready && in_valid);
  end

  // Ready is the registered complement of the next fill state, so it stays low in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= full_next;
      in_ready  <= !full_next;
      if (in_ready && in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/sph_axil_regs.sv
// AXI4-Lite slave holding NUM_REGS 32-bit control registers for the SPH core.
// Define SPH_AXIL_SLVERR_EN to answer out-of-range indices with SLVERR instead of aliasing.
module sph_axil_regs
  import sph_axil_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          NUM_REGS           = 4,
  parameter logic [31:0] RESET_VAL          = 32'h0
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]            reg_out,
  output logic [NUM_REGS-1:0]               reg_wr_pulse
);

  localparam int unsigned WORD_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned NREGS  = NUM_REGS;

  logic [DATA_W-1:0]        regs [NUM_REGS];
  logic                     aw_full, w_full, commit;
  logic [WORD_W-1:0]        aw_word;
  logic [STRB_W+DATA_W-1:0] w_bundle;
  logic [STRB_W-1:0]        w_strb;
  logic [DATA_W-1:0]        w_data;
  reg_idx_t                 wr_idx, rd_idx;
  logic                     wr_ok, rd_ok;
  logic [DATA_W-1:0]        rd_val;
  logic                     bvalid, rvalid, arready;
  axi_resp_t                bresp, rresp;
  logic [DATA_W-1:0]        rdata;
  logic                     unused_bits;

  function automatic reg_idx_t word_to_idx(input logic [WORD_W-1:0] w);
    return reg_idx_t'(32'(w) % NREGS);
  endfunction

  function automatic logic word_in_range(input logic [WORD_W-1:0] w);
    return 32'(w) < NREGS;
  endfunction

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  sph_axil_hold_buf #(.WIDTH(WORD_W)) u_aw_buf (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .in_valid (S_AXI_AWVALID),
    .in_ready (S_AXI_AWREADY),
    .in_data  (S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]),
    .out_valid(aw_full),
    .out_data (aw_word),
    .pop      (commit)
  );

  sph_axil_hold_buf #(.WIDTH(STRB_W + DATA_W)) u_w_buf (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .in_valid (S_AXI_WVALID),
    .in_ready (S_AXI_WREADY),
    .in_data  ({S_AXI_WSTRB, S_AXI_WDATA}),
    .out_valid(w_full),
    .out_data (w_bundle),
    .pop      (commit)
  );

  assign {w_strb, w_data} = w_bundle;
  assign commit = aw_full && w_full && !bvalid;

  always_comb begin
    wr_idx = word_to_idx(aw_word);
    rd_idx = word_to_idx(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
`ifdef SPH_AXIL_SLVERR_EN
    wr_ok  = word_in_range(aw_word);
    rd_ok  = word_in_range(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
`else
    wr_ok  = 1'b1;
    rd_ok  = 1'b1;
`endif
  end

  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (rd_idx == reg_idx_t'(i)) rd_val = regs[i];
    end
    if (!rd_ok) rd_val = '0;
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      reg_out[32*i +: 32] = regs[i];
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      bvalid       <= 1'b0;
      bresp        <= RESP_OKAY;
      reg_wr_pulse <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
    end else begin
      reg_wr_pulse <= '0;
      if (bvalid && S_AXI_BREADY) bvalid <= 1'b0;
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        for (int unsigned i = 0; i < NREGS; i++) begin
          if (wr_ok && wr_idx == reg_idx_t'(i)) begin
            reg_wr_pulse[i] <= 1'b1;
            for (int unsigned b = 0; b < STRB_W; b++) begin
              if (w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // ARREADY re-arms on the R handshake edge, limiting reads to one per two cycles.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else if (S_AXI_ARVALID && arready) begin
      arready <= 1'b0;
      rvalid  <= 1'b1;
      rdata   <= rd_val;
      rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (rvalid && S_AXI_RREADY) rvalid <= 1'b0;
      if (!rvalid || S_AXI_RREADY) arready <= 1'b1;
    end
  end

  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;

endmodule

// File: doc/sph_axil_regs.md
Name: sph_axil_regs

Overview:
AXI4-Lite slave register file for the SPH IP. It is the block directly downstream of the AXI master (the VIP master in simulation, the PS interconnect in hardware) and holds NUM_REGS 32-bit read/write control registers for the SPH core. It provides byte-strobed writes, readback of written values, per-register write pulses and full VALID/READY back-pressure on all five channels.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported
C_S_AXI_ADDR_WIDTH, 6, byte address width; word index = ADDR[ADDR_WIDTH-1:2]
NUM_REGS, 4, number of implemented registers, 1..2^(ADDR_WIDTH-2)
RESET_VAL, 32'h0, reset value of every register

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
reg_out  out  NUM_REGS*32  register contents to the SPH core; reg i at [32i+31:32i]
reg_wr_pulse  out  NUM_REGS  one-cycle strobe for a committed write to reg i

Behaviour:
- Single clock ACLK; ARESETN is synchronous and active-low. All state is sampled only at the rising ACLK edge.
- Reset state: all READY and VALID outputs 0; BRESP, RRESP and RDATA 0; reg_wr_pulse 0; every register equals RESET_VAL.
- Ready outputs are registered. They rise at the first edge with ARESETN=1.
- Write path: AW and W each have a one-deep holding buffer and may arrive in either order or in the same cycle.
  - AWREADY = AW buffer empty; WREADY = W buffer empty.
  - A commit occurs at the edge where both buffers are full and BVALID=0.
  - At commit: the addressed register is updated per byte where WSTRB[b]=1; reg_wr_pulse[idx] is high for the following cycle; BVALID=1 with BRESP=OKAY; both buffers clear.
  - Latency: BVALID is asserted 1 cycle after the later of the AW and W handshakes.
  - BVALID holds until BREADY. While BVALID=1, new AW/W are buffered but not committed.
- Read path:
  - AR handshake at edge N registers RDATA (the register value before edge N), sets RRESP=OKAY and RVALID=1, and drops ARREADY.
  - RVALID, RDATA and RRESP hold stable until RREADY. ARREADY returns to 1 in the cycle after the R handshake.
  - Maximum read throughput is one read per 2 cycles.
- Simultaneous write commit and read of the same register in one cycle: the read returns the old value.
- Reset mid-transaction: all buffers and pending responses are discarded, with no B or R issued.
- Word index wraps: upper unimplemented indices alias to idx mod NUM_REGS. Unaligned ADDR[1:0] is ignored.

Optional Feature:
SPH_AXIL_SLVERR_EN:
- Defined: an index >= NUM_REGS is decoded as out-of-range. Such a write changes no register, fires no pulse and returns BRESP=SLVERR (2'b10). Such a read returns RDATA=0 with RRESP=SLVERR.
- Undefined: aliasing as described above, and every response is OKAY.

Decomposition:
- Package sph_axil_pkg holds: the AXI response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, the data width constant and byte-lane count, and a reg-index typedef.
- One sub-module, sph_axil_hold_buf (one-deep valid/ready holding register, parameterised width), instantiated for AW and for W.

Test Plan:
- Sequential writes of 1, 2, 3, 4 to 0x0/0x4/0x8/0xC, then reads of the same addresses -> RDATA 1, 2, 3, 4 with every RRESP/BRESP = OKAY; reg_out = {4,3,2,1}.
- W sent 3 cycles before AW (0xA5A5A5A5 to 0x4) -> WREADY drops after the W handshake; BVALID 1 cycle after the AW handshake; reg_wr_pulse = 4'b0010 for exactly 1 cycle.
- Write 0xFFFFFFFF, then WSTRB=4'b0101 with data 0x00000000 to 0x8 -> readback 0xFF00FF00.
- BREADY held low for 10 cycles with a second AW/W queued -> second write not committed until the first B handshake; reg updates in order.
- Write 0x10 commits in the same cycle AR targets 0x0 (old value 0x1) -> RDATA=0x1; next read = 0x10.
- Address 0x14: macro off -> aliases reg 1, OKAY; macro on -> BRESP/RRESP = SLVERR, RDATA=0, reg 1 unchanged.
